// File: rtl/nand_bist_driver.sv
// Self-test driver for the 8-lane NAND user project: walks NUM_VEC operand pairs,
// checks each masked response against ~(A & B) and records the error count and first failure.
module nand_bist_driver #(
  parameter int unsigned NUM_VEC   = 256,
  parameter int unsigned RESP_LAT  = 1,
  parameter logic [7:0]  SEED      = 8'hA5,
  parameter logic [7:0]  LANE_MASK = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [7:0] drive_ui,
  output logic [7:0] drive_uio,
  input  logic [7:0] resp_uo,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] first_fail_idx,
  output logic [7:0] first_fail_resp
);

  localparam logic [3:0] LatInit = 4'(RESP_LAT);
  localparam logic [7:0] LastIdx = 8'(NUM_VEC - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] err_q, err_d;
  logic       ff_flag_q, ff_flag_d;
  logic [7:0] ff_idx_q, ff_idx_d;
  logic [7:0] ff_resp_q, ff_resp_d;

  logic [7:0] vec_b;
  logic [7:0] exp_resp;
  logic       mismatch;
  logic       sample;
  logic       launch;

  assign vec_b    = idx_q ^ SEED;
  assign exp_resp = ~(idx_q & vec_b);
  assign mismatch = |((resp_uo ^ exp_resp) & LANE_MASK);
  assign sample   = (state_q == StWait) && (cnt_q == 4'd0);
  assign launch   = !abort && start && (state_q != StWait);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks start
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) state_d = StWait;
        end
        StWait: begin
          if (sample && (idx_q == LastIdx)) state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy      = (state_q == StWait);
    done      = (state_q == StDone);
    pass      = (state_q == StDone) && (err_q == 8'd0);
    drive_ui  = (state_q == StWait) ? idx_q : 8'd0;
    drive_uio = (state_q == StWait) ? vec_b : 8'd0;
  end

  assign err_count       = err_q;
  assign first_fail_idx  = ff_idx_q;
  assign first_fail_resp = ff_resp_q;

  // Datapath next-state: vector index, latency counter and result capture
  always_comb begin
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ff_flag_d = ff_flag_q;
    ff_idx_d  = ff_idx_q;
    ff_resp_d = ff_resp_q;
    if (launch) begin
      idx_d     = 8'd0;
      cnt_d     = LatInit;
      err_d     = 8'd0;
      ff_flag_d = 1'b0;
      ff_idx_d  = 8'd0;
      ff_resp_d = 8'd0;
    end else if (!abort && (state_q == StWait)) begin
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        if (mismatch) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (!ff_flag_q) begin
            ff_flag_d = 1'b1;
            ff_idx_d  = idx_q;
            ff_resp_d = resp_uo;
          end
        end
        if (idx_q != LastIdx) begin
          idx_d = idx_q + 8'd1;
          cnt_d = LatInit;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= 8'd0;
      cnt_q     <= 4'd0;
      err_q     <= 8'd0;
      ff_flag_q <= 1'b0;
      ff_idx_q  <= 8'd0;
      ff_resp_q <= 8'd0;
    end else begin
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ff_flag_q <= ff_flag_d;
      ff_idx_q  <= ff_idx_d;
      ff_resp_q <= ff_resp_d;
    end
  end

endmodule

// File: tb/tb_nand_bist_driver.sv
// Bench for nand_bist_driver: three differently-parameterised drivers, each facing a NAND
// user-project model with selectable fault mode and response delay.
module tb_nand_bist_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       abort;
  logic [2:0] start;
  logic [2:0] busy_v, done_v, pass_v;
  logic [7:0] ui [3];
  logic [7:0] uio [3];
  logic [7:0] uo [3];
  logic [7:0] err_v [3];
  logic [7:0] fidx_v [3];
  logic [7:0] fresp_v [3];
  logic [7:0] h1 [3];
  logic [7:0] h2 [3];
  logic [7:0] h3 [3];
  logic [1:0] dly [3];
  logic [7:0] corrupt [256];
  int         mode;

  int         nv [3];
  int         lat [3];
  logic [7:0] sd [3];
  logic [7:0] mk [3];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] v0_ui, v0_uio, v0_err;
  logic       v0_busy;

  nand_bist_driver #(.NUM_VEC(256), .RESP_LAT(1), .SEED(8'hA5), .LANE_MASK(8'hFF)) u_dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort),
    .drive_ui(ui[0]), .drive_uio(uio[0]), .resp_uo(uo[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err_v[0]), .first_fail_idx(fidx_v[0]), .first_fail_resp(fresp_v[0])
  );

  nand_bist_driver #(.NUM_VEC(256), .RESP_LAT(2), .SEED(8'hA5), .LANE_MASK(8'hF7)) u_dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort),
    .drive_ui(ui[1]), .drive_uio(uio[1]), .resp_uo(uo[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err_v[1]), .first_fail_idx(fidx_v[1]), .first_fail_resp(fresp_v[1])
  );

  nand_bist_driver #(.NUM_VEC(20), .RESP_LAT(0), .SEED(8'h3C), .LANE_MASK(8'h5A)) u_dut_c (
    .clk(clk), .rst(rst), .start(start[2]), .abort(abort),
    .drive_ui(ui[2]), .drive_uio(uio[2]), .resp_uo(uo[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_count(err_v[2]), .first_fail_idx(fidx_v[2]), .first_fail_resp(fresp_v[2])
  );

  // User-project model: 0 ideal, 1 uo[3] stuck-at-1, 2 all lanes inverted, 3 per-A corruption
  function automatic logic [7:0] user_proj(input int m, input logic [7:0] a, input logic [7:0] b);
    case (m)
      1:       return ~(a & b) | 8'h08;
      2:       return a & b;
      3:       return ~(a & b) ^ corrupt[a];
      default: return ~(a & b);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      h1[i] <= user_proj(mode, ui[i], uio[i]);
      h2[i] <= h1[i];
      h3[i] <= h2[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      case (dly[i])
        2'd0:    uo[i] = user_proj(mode, ui[i], uio[i]);
        2'd1:    uo[i] = h1[i];
        2'd2:    uo[i] = h2[i];
        default: uo[i] = h3[i];
      endcase
    end
  end

  // Reference: vector k is driven during cycles 1+k*(L+1) .. (k+1)*(L+1) after the start edge
  // and sampled in its last cycle; a D-cycle user project answers the drive of cycle t-D.
  function automatic void model(input int s, input int m, input int d,
                                output int err, output int fidx, output int fresp);
    int  n = nv[s];
    int  l = lat[s];
    bit  got = 0;
    err = 0;
    fidx = 0;
    fresp = 0;
    for (int k = 0; k < n; k++) begin
      int         ts;
      logic [7:0] a, b, r, e, kk;
      ts = 1 + k * (l + 1) + l - d;
      if (ts >= 1 && ts <= n * (l + 1)) begin
        a = 8'((ts - 1) / (l + 1));
        b = a ^ sd[s];
      end else begin
        a = 8'd0;
        b = 8'd0;
      end
      r  = user_proj(m, a, b);
      kk = 8'(k);
      e  = ~(kk & (kk ^ sd[s]));
      if (((r ^ e) & mk[s]) != 8'd0) begin
        if (err < 255) err++;
        if (!got) begin
          got = 1;
          fidx = k;
          fresp = int'(r);
        end
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Start instance s and count edges (including the one sampling start) until done
  task automatic run(input int s, input int m, input logic [1:0] d, input int re_at,
                     output int cyc);
    mode = m;
    dly[s] = d;
    repeat (4) @(negedge clk);
    start[s] = 1'b1;
    @(posedge clk);
    #1;
    start[s] = 1'b0;
    cyc = 1;
    v0_ui = ui[s];
    v0_uio = uio[s];
    v0_busy = busy_v[s];
    v0_err = err_v[s];
    while (!done_v[s] && cyc < 3000) begin
      start[s] = (cyc == re_at);
      @(posedge clk);
      #1;
      cyc++;
    end
    start[s] = 1'b0;
    chk("run_reaches_done", int'(done_v[s]), 1);
  endtask

  task automatic wait_ui(input logic [7:0] v);
    int t = 0;
    while (ui[0] != v && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("wait_for_index", int'(ui[0] == v), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_drive_ui"}, int'(ui[0]), 0);
    chk({tag, "_drive_uio"}, int'(uio[0]), 0);
    chk({tag, "_busy"}, int'(busy_v[0]), 0);
    chk({tag, "_done"}, int'(done_v[0]), 0);
    chk({tag, "_pass"}, int'(pass_v[0]), 0);
    chk({tag, "_err"}, int'(err_v[0]), 0);
    chk({tag, "_fidx"}, int'(fidx_v[0]), 0);
    chk({tag, "_fresp"}, int'(fresp_v[0]), 0);
  endtask

  typedef struct {
    int sel;
    int mode;
    int dly;
    int exp_pass;
    int exp_err;   // -1: only "some errors" is required
    int exp_fidx;  // -1: not checked
    int exp_fresp;
    int exp_cyc;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int cyc, e_err, e_fidx, e_fresp, n40;
    nv  = '{256, 256, 20};
    lat = '{1, 2, 0};
    sd  = '{8'hA5, 8'hA5, 8'h3C};
    mk  = '{8'hFF, 8'hF7, 8'h5A};
    for (int i = 0; i < 256; i++) corrupt[i] = 8'h00;
    for (int i = 0; i < 3; i++) dly[i] = 2'd1;
    mode  = 0;
    rst   = 1'b1;
    abort = 1'b0;
    start = 3'b000;

    tbl[0] = '{0, 0, 1, 1, 0, 0, 8'h00, 513};
    tbl[1] = '{0, 1, 1, 0, 128, 8, 8'hFF, 513};
    tbl[2] = '{1, 1, 2, 1, 0, 0, 8'h00, 769};   // bit 3 masked off
    tbl[3] = '{0, 2, 1, 0, 255, 0, 8'h00, 513};
    tbl[4] = '{0, 0, 2, 0, -1, -1, -1, 513};    // DUT slower than RESP_LAT
    tbl[5] = '{1, 0, 2, 1, 0, 0, 8'h00, 769};
    tbl[6] = '{2, 0, 0, 1, 0, 0, 8'h00, 21};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      int s;
      s = tbl[i].sel;
      run(s, tbl[i].mode, 2'(tbl[i].dly), -1, cyc);
      chk($sformatf("row%0d_cycles", i), cyc, tbl[i].exp_cyc);
      chk($sformatf("row%0d_pass", i), int'(pass_v[s]), tbl[i].exp_pass);
      chk($sformatf("row%0d_busy", i), int'(busy_v[s]), 0);
      chk($sformatf("row%0d_drive", i), int'({ui[s], uio[s]}), 0);
      if (tbl[i].exp_err < 0) begin
        chk($sformatf("row%0d_err_nonzero", i), int'(err_v[s] != 8'd0), 1);
      end else begin
        chk($sformatf("row%0d_err", i), int'(err_v[s]), tbl[i].exp_err);
      end
      if (tbl[i].exp_fidx >= 0) begin
        chk($sformatf("row%0d_fidx", i), int'(fidx_v[s]), tbl[i].exp_fidx);
        chk($sformatf("row%0d_fresp", i), int'(fresp_v[s]), tbl[i].exp_fresp);
      end
    end

    // Vector 0 timing, and a start pulse during WAIT that must be ignored
    run(0, 0, 2'd1, 10, cyc);
    chk("v0_ui", int'(v0_ui), 8'h00);
    chk("v0_uio", int'(v0_uio), 8'hA5);
    chk("v0_busy", int'(v0_busy), 1);
    chk("restart_ignored_cycles", cyc, 513);
    chk("restart_ignored_pass", int'(pass_v[0]), 1);

    // Abort at vector 40 with uo[3] stuck: results kept, outputs idle
    mode = 1;
    repeat (4) @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_ui(8'd40);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n40 = 0;
    for (int k = 0; k < 40; k++) if ((k & 8) != 0) n40++;
    chk("abort_busy", int'(busy_v[0]), 0);
    chk("abort_done", int'(done_v[0]), 0);
    chk("abort_pass", int'(pass_v[0]), 0);
    chk("abort_drive", int'({ui[0], uio[0]}), 0);
    chk("abort_err_kept", int'(err_v[0]), n40);
    chk("abort_fidx_kept", int'(fidx_v[0]), 8);
    run(0, 0, 2'd1, -1, cyc);
    chk("after_abort_err_cleared", int'(v0_err), 0);
    chk("after_abort_pass", int'(pass_v[0]), 1);

    // Reset mid-run after exactly one error
    mode = 1;
    repeat (4) @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_ui(8'd9);
    chk("pre_rst_err", int'(err_v[0]), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("midrun_rst");
    rst = 1'b0;
    run(0, 0, 2'd1, -1, cyc);
    chk("after_rst_cycles", cyc, 513);
    chk("after_rst_pass", int'(pass_v[0]), 1);

    // Randomised runs against the reference model
    for (int it = 0; it < 8; it++) begin
      int s, m, d;
      s = $urandom_range(0, 2);
      m = $urandom_range(0, 3);
      d = $urandom_range(0, 3);
      for (int i = 0; i < 256; i++) corrupt[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      run(s, m, 2'(d), -1, cyc);
      model(s, m, d, e_err, e_fidx, e_fresp);
      chk($sformatf("rnd%0d_cycles", it), cyc, nv[s] * (lat[s] + 1) + 1);
      chk($sformatf("rnd%0d_err", it), int'(err_v[s]), e_err);
      chk($sformatf("rnd%0d_fidx", it), int'(fidx_v[s]), e_fidx);
      chk($sformatf("rnd%0d_fresp", it), int'(fresp_v[s]), e_fresp);
      chk($sformatf("rnd%0d_pass", it), int'(pass_v[s]), int'(e_err == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
